// File: rtl/fifo_ptr_pkg.sv
// Shared definitions for the async-FIFO pointer blocks: pointer width and reset constants.
package fifo_ptr_pkg;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam logic PTR_RST_BIT = 1'b0;
  localparam logic FLAG_RST    = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray pointer entering this clock domain; shared by both pointer blocks.
module sync_2ff
  import fifo_ptr_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= {W{PTR_RST_BIT}};
      q        <= {W{PTR_RST_BIT}};
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/gray_ptr_wr.sv
// Write-side async FIFO pointer: binary/Gray write pointer, synchronised read pointer, full and level.
// Optional almost-full flag is built when GRAY_PTR_WR_AFULL_EN is defined.
module gray_ptr_wr
  import fifo_ptr_pkg::*;
#(
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_AFULL_THRESH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req,
  input  logic [C_ADDR_WIDTH:0]   rptr_gray_async,
  output logic                    wr_en,
  output logic [C_ADDR_WIDTH-1:0] waddr,
  output logic [C_ADDR_WIDTH:0]   wptr_gray,
  output logic                    full,
  output logic [C_ADDR_WIDTH:0]   wlevel
`ifdef GRAY_PTR_WR_AFULL_EN
  ,
  output logic                    afull
`endif
);

  localparam int A  = C_ADDR_WIDTH;
  localparam int PW = ptr_width(C_ADDR_WIDTH);

  logic [PW-1:0] wbin_reg;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_ptr;
  logic [PW-1:0] level_next;

  sync_2ff #(.W(PW)) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray_async),
    .q   (rq2)
  );

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_gray_dec
    assign rbin_s[gi] = ^(rq2 >> gi);
  end

  assign wr_en      = wr_req & ~full;
  assign wbin_next  = wbin_reg + {{A{1'b0}}, wr_en};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign level_next = wbin_next - rbin_s;
  assign waddr      = wbin_reg[A-1:0];

  // Full when the write pointer is exactly one lap ahead of the read pointer, in Gray form.
  assign full_ptr   = {~rq2[A:A-1], rq2[A-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_reg  <= {PW{PTR_RST_BIT}};
      wptr_gray <= {PW{PTR_RST_BIT}};
      full      <= FLAG_RST;
      wlevel    <= {PW{PTR_RST_BIT}};
    end else begin
      wbin_reg  <= wbin_next;
      wptr_gray <= wgray_next;
      full      <= (wgray_next == full_ptr);
      wlevel    <= level_next;
    end
  end

`ifdef GRAY_PTR_WR_AFULL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      afull <= FLAG_RST;
    end else begin
      afull <= (32'(level_next) >= $unsigned(C_AFULL_THRESH));
    end
  end
`else
  logic unused_afull_thresh;
  assign unused_afull_thresh = ^C_AFULL_THRESH;
`endif

endmodule

// File: tb/tb_gray_ptr_wr.sv
// Scoreboard bench for gray_ptr_wr (C_ADDR_WIDTH=4); afull checks when GRAY_PTR_WR_AFULL_EN is defined.
module tb_gray_ptr_wr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_req = 1'b0;
  logic [4:0] rptr_gray_async = 5'd0;
  logic       wr_en;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       full;
  logic [4:0] wlevel;
  logic       afull;

  always #5 clk = ~clk;

  gray_ptr_wr #(.C_ADDR_WIDTH(4), .C_AFULL_THRESH(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_req          (wr_req),
    .rptr_gray_async (rptr_gray_async),
    .wr_en           (wr_en),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .wlevel          (wlevel)
`ifdef GRAY_PTR_WR_AFULL_EN
    ,
    .afull           (afull)
`endif
  );

`ifndef GRAY_PTR_WR_AFULL_EN
  assign afull = 1'b0;
`endif

  // Hand-written 5-bit Gray code table.
  logic [4:0] gray_tab [32] = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4,
                                5'd12, 5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8,
                                5'd24, 5'd25, 5'd27, 5'd26, 5'd30, 5'd31, 5'd29, 5'd28,
                                5'd20, 5'd21, 5'd23, 5'd22, 5'd18, 5'd19, 5'd17, 5'd16};

  typedef struct {
    logic       wr_en;
    logic [3:0] waddr;
    logic [4:0] gray;
    logic       full;
    logic [4:0] level;
    logic       afull;
    bit         onebit;
  } entry_t;

  entry_t sb[$];
  int total = 0;
  int bad = 0;
  int txn = 0;

  // Behavioural model: binary counts, read pointer delayed through two stages.
  logic [4:0] m_wbin, m_rq1, m_rq2, m_level;
  logic       m_full, m_afull;
  bit         onebit_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wbin = 5'd0; m_rq1 = 5'd0; m_rq2 = 5'd0; m_level = 5'd0;
    m_full = 1'b0; m_afull = 1'b0; onebit_ok = 1'b0;
  endtask

  // One clock cycle of stimulus; called at posedge+1.
  task automatic cycle(input logic req, input logic [4:0] rb);
    entry_t e;
    logic [4:0] nx, lvl;
    wr_req = req;
    rptr_gray_async = gray_tab[rb];
    e.wr_en  = req & ~m_full;
    e.waddr  = m_wbin[3:0];
    e.gray   = gray_tab[m_wbin];
    e.full   = m_full;
    e.level  = m_level;
    e.afull  = m_afull;
    e.onebit = onebit_ok;
    sb.push_back(e);
    nx = m_wbin + {4'd0, e.wr_en};
    lvl = nx - m_rq2;
    m_full  = (lvl == 5'd16);
    m_afull = (lvl >= 5'd12);
    m_level = lvl;
    m_rq2 = m_rq1;
    m_rq1 = rb;
    m_wbin = nx;
    onebit_ok = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 32'd0);
    chk({tag, ".wptr_gray"}, 32'(wptr_gray), 32'd0);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".wlevel"}, 32'(wlevel), 32'd0);
    chk({tag, ".afull"}, 32'(afull), 32'd0);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(wr_req));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    wr_req = 1'b1;
    rptr_gray_async = 5'd0;
    @(posedge clk); #1;
    chk_zero("reset");
    wr_req = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compares every scoreboard entry mid-cycle.
  initial begin : monitor
    entry_t e;
    logic [4:0] prev_gray = 5'd0;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: wr_en=%0d waddr=%0d wptr_gray=%05b full=%0d wlevel=%0d",
                 txn, wr_en, waddr, wptr_gray, full, wlevel);
        chk("wr_en", 32'(wr_en), 32'(e.wr_en));
        chk("waddr", 32'(waddr), 32'(e.waddr));
        chk("wptr_gray", 32'(wptr_gray), 32'(e.gray));
        chk("full", 32'(full), 32'(e.full));
        chk("wlevel", 32'(wlevel), 32'(e.level));
`ifdef GRAY_PTR_WR_AFULL_EN
        chk("afull", 32'(afull), 32'(e.afull));
`endif
        if (e.onebit) begin
          total++;
          if ($countones(prev_gray ^ wptr_gray) > 1) begin
            bad++;
            $display("FAIL gray_onebit: got %05b after %05b required at most one bit change",
                     wptr_gray, prev_gray);
          end
        end
        prev_gray = wptr_gray;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    model_reset();
    #2;
    chk_zero("por");
    @(posedge clk); #1;
    reset_dut();

    // Fill to full with the read pointer parked at 0.
    for (int i = 0; i < 16; i++) cycle(1'b1, 5'd0);
    // Requests while full are dropped.
    for (int i = 0; i < 5; i++) cycle(1'b1, 5'd0);
    // One pop: full and level update three edges later.
    for (int i = 0; i < 5; i++) cycle(1'b0, 5'd1);

    // Settle read pointer one behind the writer, then stream with level 4 across the wrap.
    for (int i = 0; i < 3; i++) cycle(1'b0, m_wbin - 5'd1);
    for (int i = 0; i < 40; i++) cycle(1'b1, m_wbin - 5'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, m_wbin);

    // Asynchronous reset mid-burst at wbin=9.
    reset_dut();
    for (int i = 0; i < 9; i++) cycle(1'b1, 5'd0);
    chk("pre_rst.waddr", 32'(waddr), 32'd9);
    wr_req = 1'b1;
    rst = 1'b1;
    #2;
    chk_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd0);

`ifdef GRAY_PTR_WR_AFULL_EN
    // Almost-full at threshold 12: level 11 keeps it low, level 12 raises it.
    reset_dut();
    for (int i = 0; i < 11; i++) cycle(1'b1, 5'd0);
    cycle(1'b0, 5'd0);
    chk("afull_at_11", 32'(afull), 32'd0);
    cycle(1'b1, 5'd0);
    cycle(1'b0, 5'd0);
    chk("afull_at_12", 32'(afull), 32'd1);
`endif

    wr_req = 1'b0;
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_ptr_wr.md
# gray_ptr_wr

Write-side pointer generator for the asynchronous FIFOs in the image pipeline; the binary-to-Gray counterpart of the pointer decode done on the read side. It keeps a binary write pointer and publishes a registered Gray-coded copy for clock-domain crossing. It synchronises the read side's Gray pointer into the write clock with two flops and decodes it to binary. From that it produces the memory write address, a registered `full` flag and a fill level.

## Interface
- `C_ADDR_WIDTH`, 4: FIFO address width; depth = 2^C_ADDR_WIDTH; pointers are C_ADDR_WIDTH+1 bits.
- `C_AFULL_THRESH`, 12: almost-full threshold in entries (only with the macro in Configuration).
- `clk` input 1: write-domain clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wr_req` input 1: push request.
- `rptr_gray_async` input C_ADDR_WIDTH+1: Gray read pointer from the read clock domain, unsynchronised.
- `wr_en` output 1: push accepted this cycle, combinational `wr_req & ~full`; drives the RAM write enable.
- `waddr` output C_ADDR_WIDTH: RAM write address = `wbin[C_ADDR_WIDTH-1:0]`.
- `wptr_gray` output C_ADDR_WIDTH+1: registered Gray write pointer, exported to the read domain.
- `full` output 1: registered full flag.
- `wlevel` output C_ADDR_WIDTH+1: registered entries in use, as seen from the write domain.
- `afull` output 1: registered almost-full flag (only with the macro).

## Operation
- State:
  - `wbin` (binary pointer);
  - `wptr_gray`;
  - `rq1`, `rq2` (two-flop synchroniser on `rptr_gray_async`);
  - `full`;
  - `wlevel`;
  - `afull`.
- Accept: `wr_en = wr_req & ~full`. A request while full is dropped; there is no pending state.
- Next pointer: `wbin_nx = wbin + wr_en`, modulo 2^(C_ADDR_WIDTH+1). It wraps from all-ones to 0 with no special handling.
- Encode: `wgray_nx = (wbin_nx >> 1) ^ wbin_nx`. Each cycle `wptr_gray <= wgray_nx`. Only one bit of `wptr_gray` ever changes per cycle.
- Full: `full <= (wgray_nx == {~rq2[A:A-1], rq2[A-2:0]})` with A = C_ADDR_WIDTH. That is, the top two bits are inverted and the rest are equal.
- Synchronised read pointer decode: `rbin_s[i] = ^(rq2 >> i)` for every bit i.
- Level: `wlevel <= wbin_nx - rbin_s`, modulo 2^(A+1). The range is 0..2^A.
- Flags are pessimistic:
  - a read-side pop reaches `full`/`wlevel` 2–3 cycles later;
  - a write updates them immediately.
- A push and a stale-synchronised pop in the same cycle need no special handling; the equations above apply unchanged.
- Reset mid-operation: all state returns to zero asynchronously. The read side must be reset in the same event; this block does not handshake reset.

## Timing
- Reset values:
  - `wbin`, `wptr_gray`, `rq1`, `rq2` = 0;
  - `full` = 0, `wlevel` = 0, `afull` = 0;
  - `waddr` = 0;
  - `wr_en` follows `wr_req`.
- `wr_en` is combinational in the same cycle as `wr_req`.
- `waddr`, `wptr_gray` and `wlevel` reflect an accepted push on the next rising edge.
- `full` asserts on the edge that registers the 2^A-th unread entry. A `wr_req` in the following cycle is refused.
- Read pointer latency: a `rptr_gray_async` change first affects `full`/`wlevel` 3 edges later:
  - `rq1`;
  - `rq2`;
  - the flag register.
- Sustained throughput: one push per clock while not full.

## Configuration
- `GRAY_PTR_WR_AFULL_EN`:
  - Defined: the `afull` port and register exist, with `afull <= (wbin_nx - rbin_s) >= C_AFULL_THRESH`.
  - Undefined: the port and its logic are absent, and `C_AFULL_THRESH` is unused.

## Structure
- Shared package `fifo_ptr_pkg`: the pointer-width function (C_ADDR_WIDTH+1) and the reset constants for the pointers.
- One sub-module, `sync_2ff`: parameterised-width two-flop synchroniser with asynchronous `rst`. It is reused by the read-side pointer block.
- Gray decode of `rq2` is an inline generate loop in this block.

## Test plan
All scenarios use C_ADDR_WIDTH=4.
- Reset, then `rptr_gray_async`=0 and `wr_req`=1 for 16 cycles:
  - `wptr_gray` steps 00000, 00001, 00011, 00010, …;
  - `waddr` steps 0..15;
  - `full`=1 after the 16th edge;
  - `wlevel`=16.
- While full, hold `wr_req`=1 for 5 cycles → `wr_en`=0 and `wbin` unchanged.
- From full, set `rptr_gray_async`=00001 (one pop) → `full` deasserts and `wlevel`=15 exactly 3 edges later.
- Run continuous push/pop for 40 pushes with the read pointer trailing by 4 → pointer wraps 31→0 cleanly, `wlevel` stays 4, `full` never asserts, and `wptr_gray` changes exactly one bit per edge.
- Assert `rst` asynchronously mid-burst (`wbin`=9) → all outputs drop to 0 before the next edge, and pushing resumes from `waddr`=0.
- With `GRAY_PTR_WR_AFULL_EN` and threshold 12, push 11 then 12 entries → `afull` stays 0 at 11 and becomes 1 on the 12th push edge.
